// File: rtl/nanorv32_trace_buf.sv
// Trace buffer for the nanorv32 core: first-word-fall-through FIFO that
// captures core trace words without backpressure, counts dropped words,
// and drains to completion after a trap.
module nanorv32_trace_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  trace_valid,
    input  logic [35:0]           trace_data,
    input  logic                  trap,
    output logic                  out_valid,
    output logic [35:0]           out_data,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic [CNT_W-1:0]      overflow_count,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    level_q, level_d;
    logic [CNT_W-1:0]       ovf_q, ovf_d;
    logic [35:0]            mem_q [DEPTH];

    logic                   accept;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // Push/pop/drop decisions and next pointer, level and drop-counter values.
    // Level is kept separately from the pointers so full and empty never alias.
    always_comb begin
        pop      = (level_q != '0) && out_ready;
        accept   = trace_valid && (state_q == ST_RUN);
        push     = accept && ((level_q != DEPTH_LVL) || pop);
        drop     = accept && (level_q == DEPTH_LVL) && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (DEPTH_LOG2+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (DEPTH_LOG2+1)'(1);
        end
        // Saturate rather than wrap so a long overflow never reads as small.
        if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
    end

    // Control state: pointers, occupancy, drop counter and FSM state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= trace_data;
        end
    end

    // Next-state: a trap starts draining; done once the buffer is empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (trap) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No pushes happen in DRAIN, so level_d == 0 covers both
                // "becomes empty this edge" and "was already empty".
                if (level_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs: FWFT view of the oldest word plus status.
    always_comb begin
        out_valid      = (level_q != '0);
        out_data       = mem_q[rd_ptr_q];
        level          = level_q;
        overflow_count = ovf_q;
        done           = (state_q == ST_DONE);
    end

endmodule
